// File: rtl/int_to_fp8_stream.sv
// Multi-lane signed integer to FP8 (1-4-3) converter with valid/ready handshake.
// Two-stage pipeline: S1 holds sign/magnitude/mode, S2 holds the encoded beat.
module int_to_fp8_stream #(
    parameter int INT_BITS = 20,
    parameter int LANES    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*INT_BITS-1:0] in_data,
    input  logic                      rnd_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*8-1:0]        out_data,
    output logic [LANES-1:0]          out_sat,
    input  logic                      sat_clr,
    output logic [15:0]               sat_cnt
);
    localparam int EW = INT_BITS + 5;

    logic                      s1_valid;
    logic [LANES-1:0]          s1_sign;
    logic [LANES*INT_BITS-1:0] s1_mag;
    logic                      s1_rnd;
    logic                      s2_adv;
    logic [LANES-1:0]          in_sign;
    logic [LANES*INT_BITS-1:0] in_mag;
    logic [LANES*8-1:0]        conv_data;
    logic [LANES-1:0]          conv_sat;
    logic [4:0]                sat_pop;
    logic [16:0]               sat_sum;

    // Returns {sat, fp8}. The magnitude is normalised so its leading one sits at
    // the top; five zero guard bits below it make round/sticky read 0 when absent.
    function automatic logic [8:0] encode(input logic sign, input logic [INT_BITS-1:0] mag,
                                          input logic rnd);
        logic [5:0]    p;
        logic [EW-1:0] norm;
        logic [2:0]    mant;
        logic          rbit;
        logic          sticky;
        logic          inc;
        logic [3:0]    mant_sum;
        logic [6:0]    expo;
        p = '0;
        for (int i = 0; i < INT_BITS; i++) begin
            if (mag[i]) p = 6'(i);
        end
        norm     = {mag, 5'b0} << (6'(INT_BITS - 1) - p);
        mant     = norm[EW-2 -: 3];
        rbit     = norm[EW-5];
        sticky   = |norm[EW-6:0];
        inc      = rnd && rbit && (sticky || mant[0]);
        mant_sum = {1'b0, mant} + {3'b0, inc};
        expo     = {1'b0, p} - 7'd3 + {6'b0, mant_sum[3]};
        // Zero or below 8: flushed to signed zero.
        if (!norm[EW-1] || p < 6'd3) begin
            encode = {1'b0, sign, 7'd0};
        end else if (p > 6'd18 || expo > 7'd15) begin
            encode = {1'b1, sign, 7'h7F};
        end else begin
            encode = {1'b0, sign, expo[3:0], mant_sum[2:0]};
        end
    endfunction

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_comb begin
        in_sign = '0;
        in_mag  = '0;
        for (int i = 0; i < LANES; i++) begin
            in_sign[i] = in_data[i*INT_BITS + INT_BITS - 1];
            in_mag[i*INT_BITS +: INT_BITS] = in_sign[i] ? -in_data[i*INT_BITS +: INT_BITS]
                                                        :  in_data[i*INT_BITS +: INT_BITS];
        end
    end

    always_comb begin
        conv_data = '0;
        conv_sat  = '0;
        for (int i = 0; i < LANES; i++) begin
            {conv_sat[i], conv_data[i*8 +: 8]} = encode(s1_sign[i], s1_mag[i*INT_BITS +: INT_BITS],
                                                        s1_rnd);
        end
    end

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_pop = sat_pop + {4'b0, out_sat[i]};
        end
        sat_sum = {1'b0, sat_cnt} + {12'b0, sat_pop};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= '0;
            s1_mag   <= '0;
            s1_rnd   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
                s1_rnd  <= rnd_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= conv_data;
                out_sat  <= conv_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

endmodule

// File: doc/int_to_fp8_stream.md
INT_TO_FP8_STREAM -- requirements
Module: int_to_fp8_stream

Interface
REQ-001 SHALL have parameter INT_BITS, default 20, signed two's-complement input width per lane (legal 5..32).
REQ-002 SHALL have parameter LANES, default 4, number of parallel conversion lanes (legal 1..16).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port in_data  input  LANES*INT_BITS  lane i at bits [i*INT_BITS +: INT_BITS].
REQ-008 SHALL have port rnd_en  input  1  per-beat mode: 1 = round-to-nearest-even, 0 = truncate.
REQ-009 SHALL have port out_valid  output  1  output beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port out_data  output  LANES*8  lane i FP8 at bits [i*8 +: 8].
REQ-012 SHALL have port out_sat  output  LANES  per-lane saturation flag for current out beat.
REQ-013 SHALL have port sat_clr  input  1  synchronous clear of sat_cnt.
REQ-014 SHALL have port sat_cnt  output  16  saturating count of saturated lanes delivered.

Function
REQ-015 SHALL encode each lane as {sign, exp[3:0], mant[2:0]}; sign = input MSB, always preserved.
REQ-016 SHALL compute magnitude INT_BITS wide (no truncation), so most-negative input yields 2^(INT_BITS-1).
REQ-017 SHALL, for magnitude >= 8 with leading-one position p, set exp = p-3 and mant = mag[p-1:p-3].
REQ-018 SHALL, for magnitude < 8, output exp = 0, mant = 0 (flush), both modes.
REQ-019 SHALL, when rnd_en = 1, use round bit mag[p-4] (absent if p < 4) and sticky = OR of mag[p-5:0] (absent if p < 5); increment mant when round AND (sticky OR mant[0]).
REQ-020 SHALL propagate mantissa carry: mant 111 + 1 -> mant 000, exp + 1.
REQ-021 SHALL saturate when p > 18 or rounded exp > 15: output {sign, 1111, 111}, out_sat lane bit = 1.
REQ-022 SHALL capture rnd_en together with in_data on acceptance; mode travels with its beat.
REQ-023 SHALL be a 2-stage pipeline: S1 registers sign/magnitude/mode, S2 registers out_data/out_sat; latency 2 cycles from accepting edge to out_valid with no stall.
REQ-024 SHALL transfer on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-025 SHALL advance S2 when S2 empty or out_ready = 1; S1 advances when S1 empty or S2 advances; in_ready = !S1_valid || S2 advances.
REQ-026 SHALL sustain one beat per cycle with out_ready held high; no beat dropped, duplicated or reordered.
REQ-027 SHALL hold out_data/out_sat stable while out_valid && !out_ready.
REQ-028 SHALL add popcount(out_sat) to sat_cnt on each output transfer, saturating at 0xFFFF.
REQ-029 SHALL give sat_clr priority: same-cycle increment is dropped, sat_cnt becomes 0.

Reset
REQ-030 SHALL, on rising clk with reset = 0, clear both stage valids, out_data, out_sat, sat_cnt to 0.
REQ-031 SHALL ignore in_valid during reset cycles; in_ready = 1 on the first cycle after reset release.
REQ-032 SHALL discard in-flight beats on reset mid-operation; no output produced for them.

Verification (INT_BITS=20, LANES=4; lane 0 shown)
REQ-033 SHALL cover: +3000, rnd_en=0 -> 0x43; rnd_en=1 -> 0x44; out_sat=0; out_valid 2 cycles after accept.
REQ-034 SHALL cover: -15 -> 0x87; -5 -> 0x80; 0 -> 0x00; +31 rnd_en=1 -> 0x10 (tie, carry into exp).
REQ-035 SHALL cover: -524288 -> 0xFF, out_sat=1; +524287 rnd_en=0 -> 0x7F sat=0; rnd_en=1 -> 0x7F sat=1.
REQ-036 SHALL cover: 4 beats back-to-back, out_ready=0 for 3 cycles -> in_ready low after 2 beats held, all 4 delivered in order, out_data stable while stalled.
REQ-037 SHALL cover: reset=0 while out_valid=1 -> next cycle out_valid=0, out_data=0, sat_cnt=0.
REQ-038 SHALL cover: sat_cnt=5, beat with 3 saturated lanes delivered same cycle as sat_clr=1 -> sat_cnt=0; next such beat -> 3.
